gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the counter width in bits; legal range 2 to 16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port clr, input, 1 bit: synchronous clear to zero.
REQ-005 The module SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-006 The module SHALL have port load_val, input, N bits: binary value to load.
REQ-007 The module SHALL have port en, input, 1 bit: count enable.
REQ-008 The module SHALL have port up_dn, input, 1 bit: count direction, 1 = increment, 0 = decrement.
REQ-009 The module SHALL have port bin_cnt, output, N bits: registered binary count.
REQ-010 The module SHALL have port gray_cnt, output, N bits: registered Gray-coded count, always equal to bin_cnt ^ (bin_cnt >> 1).
REQ-011 The module SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a wrap-around.

Function
REQ-012 Each rising clk edge SHALL apply the highest-priority active command: clr > load > en > hold.
REQ-013 With clr=1, bin_cnt SHALL become 0, gray_cnt SHALL become 0 and wrap SHALL become 0.
REQ-014 With clr=0 and load=1, bin_cnt SHALL become load_val, gray_cnt SHALL become Gray(load_val) and wrap SHALL become 0; en and up_dn are ignored that cycle.
REQ-015 With clr=0, load=0, en=1 and up_dn=1, bin_cnt SHALL become (bin_cnt+1) mod 2^N.
REQ-016 With clr=0, load=0, en=1 and up_dn=0, bin_cnt SHALL become (bin_cnt-1) mod 2^N.
REQ-017 With clr=0, load=0 and en=0, bin_cnt and gray_cnt SHALL hold their values and wrap SHALL become 0.
REQ-018 wrap SHALL be 1 for exactly the cycle after an edge where en caused a count from 2^N-1 to 0 (up) or from 0 to 2^N-1 (down); it SHALL be 0 otherwise.
REQ-019 Latency: bin_cnt, gray_cnt and wrap SHALL all reflect a command on the same edge that samples it (one-cycle registered); no combinational path from inputs to outputs.
REQ-020 gray_cnt SHALL be driven directly from a flop, computed from the next binary value before the register, so it never glitches.
REQ-021 Between consecutive enabled counts, gray_cnt SHALL change in exactly one bit, including across wrap-around in both directions.
REQ-022 A direction change (up_dn toggling while en=1) SHALL take effect on the same edge, with no skipped or repeated value.
REQ-023 Arithmetic SHALL use N-bit modular width; no carry-out is retained other than the wrap pulse.

Reset
REQ-024 While rst_n=0, bin_cnt, gray_cnt and wrap SHALL be forced to 0 immediately, independent of clk.
REQ-025 Reset asserted mid-count SHALL discard any in-progress value; after release, counting SHALL resume from 0 on the first enabled edge.
REQ-026 Reset deassertion SHALL only take effect at a clk edge with no other input active, so no spurious wrap occurs.

Structure
REQ-027 A shared package SHALL hold the default width constant and a function computing Gray(x) = x ^ (x >> 1), used by both RTL and bench.
REQ-028 gray_counter SHALL instantiate the team's existing binary_to_gray sub-module (parameter N) on the next-state binary value; it SHALL contain no other sub-modules.
REQ-029 State SHALL consist of the N-bit binary register, the N-bit Gray register and the wrap flop only.

Verification
REQ-030 With N=4: reset, then en=1, up_dn=1 for 16 cycles -> bin_cnt 0..15 then 0; gray_cnt follows 0000,0001,0011,0010,...,1000,0000; wrap=1 only after the 15->0 edge.
REQ-031 With N=4: load=1, load_val=0000, then en=1, up_dn=0 -> bin_cnt=15, gray_cnt=1000, wrap=1 for one cycle.
REQ-032 With N=4: clr=1, load=1, load_val=1010 and en=1 on the same edge -> bin_cnt=0, gray_cnt=0 (clr wins); load alone -> bin_cnt=1010, gray_cnt=1111.
REQ-033 With N=4: at bin_cnt=5, drive en=0 for 3 cycles, then en=1 with up_dn toggling each cycle -> outputs hold at 5/0111, then alternate 6, 5, 6 with a single-bit Gray change each step.
REQ-034 With N=4: assert rst_n=0 between clk edges at bin_cnt=9 -> outputs become 0 before the next edge; after release, first enabled up edge gives bin_cnt=1.
REQ-035 Across every scenario, an assertion SHALL check gray_cnt == Gray(bin_cnt) every cycle and a Hamming distance of 1 per enabled count.

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared constants and the Gray-code conversion used by the counter and its bench.
package gray_counter_pkg;

  localparam int DEFAULT_N = 4;
  localparam int MAX_N     = 16;

  // Operates at the widest supported width; callers narrow the result to their own N.
  function automatic logic [MAX_N-1:0] gray_of(input logic [MAX_N-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_binary_to_gray.sv
// Combinational binary-to-Gray converter.
module binary_to_gray
  import gray_counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = N'(gray_of(MAX_N'(bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a glitch-free registered Gray-code output and a wrap pulse.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up_dn,
  output logic [N-1:0] bin_cnt,
  output logic [N-1:0] gray_cnt,
  output logic         wrap
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] bin_next;
  logic [N-1:0] gray_next;
  logic         wrap_next;

  always_comb begin
    bin_next  = bin_cnt;
    wrap_next = 1'b0;
    if (clr) begin
      bin_next = '0;
    end else if (load) begin
      bin_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_next  = bin_cnt + ONE;
        wrap_next = &bin_cnt;
      end else begin
        bin_next  = bin_cnt - ONE;
        wrap_next = ~|bin_cnt;
      end
    end
  end

  // Gray is derived from the next binary value so its register output changes cleanly.
  binary_to_gray #(.N(N)) u_b2g (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt  <= '0;
      gray_cnt <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_cnt  <= bin_next;
      gray_cnt <= gray_next;
      wrap     <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Directed and randomized checks of gray_counter against an arithmetic reference model.
module tb_gray_counter;
  import gray_counter_pkg::*;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic [N-1:0] bin_cnt;
  logic [N-1:0] gray_cnt;
  logic         wrap;

  int total = 0;
  int bad   = 0;
  int m_bin = 0;
  int m_wrap = 0;
  // Reflected binary Gray sequence for 4 bits, indexed by binary value.
  int gray4 [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  gray_counter #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up_dn    (up_dn),
    .bin_cnt  (bin_cnt),
    .gray_cnt (gray_cnt),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [N-1:0] lv,
                      input logic e, input logic u);
    logic [N-1:0] g_before;
    clr      = c;
    load     = l;
    load_val = lv;
    en       = e;
    up_dn    = u;
    g_before = gray_cnt;
    m_wrap   = 0;
    if (c) m_bin = 0;
    else if (l) m_bin = int'(lv);
    else if (e) begin
      if (u) begin
        m_wrap = (m_bin == MOD - 1) ? 1 : 0;
        m_bin  = (m_bin + 1) % MOD;
      end else begin
        m_wrap = (m_bin == 0) ? 1 : 0;
        m_bin  = (m_bin + MOD - 1) % MOD;
      end
    end
    @(posedge clk);
    #1;
    check("bin", 32'(bin_cnt), 32'(m_bin));
    check("gray", 32'(gray_cnt), 32'(gray4[m_bin]));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("gray_of_bin", 32'(gray_cnt), 32'(N'(gray_of(16'(bin_cnt)))));
    if (!c && !l && e) check("hamming", 32'($countones(gray_cnt ^ g_before)), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_bin", 32'(bin_cnt), 32'd0);
    check("rst_gray", 32'(gray_cnt), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    #10 rst_n = 1'b1;

    // Full up sweep, ending in the 15 -> 0 wrap.
    repeat (16) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Load zero then count down through the wrap.
    step(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Clear beats load and count; then load alone.
    step(1'b1, 1'b1, 4'b1010, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'b1010, 1'b0, 1'b0);

    // Hold at 5, then alternate direction each enabled edge.
    step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset between edges at count 9.
    step(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
    en = 1'b0; load = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bin", 32'(bin_cnt), 32'd0);
    check("async_rst_gray", 32'(gray_cnt), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    m_bin  = 0;
    m_wrap = 0;
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Randomized command mix.
    repeat (400) begin
      step(($urandom_range(15) == 0), ($urandom_range(7) == 0), N'($urandom),
           ($urandom_range(3) != 0), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
